imem_fetch_buffer: RTL and testbench

Parametrised successor to the single-entry IMEM interface. It issues pipelined reads to the instruction memory, which has a fixed read latency of MEM_LAT cycles. Returning instructions are captured in a DEPTH-entry buffer tagged with their PC, so a decode stall never loses or re-fetches an instruction. A flush kills everything in flight for branch or jump redirects; the block sits between PC-gen and decode in stage 1.

---
 rtl/imem_fetch_buffer_pkg.sv | 10 +
 rtl/imem_fetch_fifo.sv | 41 ++++
 rtl/imem_fetch_buffer.sv | 83 ++++++++
 tb/tb_imem_fetch_buffer.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/imem_fetch_buffer_pkg.sv
// imem_fetch_buffer_pkg: shared stage-1 fetch types and constants.
package imem_fetch_buffer_pkg;
    localparam int MEM_LAT_MAX = 4;
    localparam int PC_W = 32;
    localparam logic [31:0] NOP = 32'h0000_0013;
    typedef struct packed {
        logic            valid;
        logic [PC_W-1:0] pc;
    } fetch_tag_t;
endpackage

// File: rtl/imem_fetch_fifo.sv
// imem_fetch_fifo: generic DEPTH x W synchronous FIFO, head read combinationally from storage.
module imem_fetch_fifo #(
    parameter int DEPTH = 2,
    parameter int W = 64,
    localparam int PW = $clog2(DEPTH)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] wdata,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty,
    output logic [PW:0]  count
);
    logic [W-1:0] mem [DEPTH];
    logic [PW-1:0] wp, rp;
    always_ff @(posedge clk) begin
        if (push) mem[wp] <= wdata;
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wp <= '0;
            rp <= '0;
            count <= '0;
        end else if (clr) begin
            wp <= '0;
            rp <= '0;
            count <= '0;
        end else begin
            wp <= wp + PW'(push);
            rp <= rp + PW'(pop);
            count <= count + (PW+1)'(push) - (PW+1)'(pop);
        end
    end
    assign rdata = mem[rp];
    assign full = count == (PW+1)'(DEPTH);
    assign empty = count == '0;
endmodule

// File: rtl/imem_fetch_buffer.sv
// imem_fetch_buffer: pipelined IMEM fetch with a PC-tagged instruction buffer and credit-based issue.
// Define IMEM_BYPASS_EN to forward a returning response straight to decode when the buffer is empty.
module imem_fetch_buffer
    import imem_fetch_buffer_pkg::*;
#(
    parameter int AW = 32,
    parameter int DW = 32,
    parameter int MEM_LAT = 1,
    parameter int DEPTH = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [AW-1:0] pc,
    input  logic          pc_valid,
    output logic          pc_ready,
    input  logic          flush,
    input  logic          stall,
    output logic [AW-1:0] addr,
    output logic          re,
    input  logic [DW-1:0] dout,
    output logic [DW-1:0] inst,
    output logic [AW-1:0] inst_pc,
    output logic          inst_valid
);
    localparam int PW = $clog2(DEPTH);
    logic [MEM_LAT-1:0] tv;
    logic [AW-1:0] tpc [MEM_LAT];
    logic [AW-1:0] last_addr;
    logic [PW:0] inflight, count, cnt;
    logic [DW+AW-1:0] head;
    logic ret, byp, push, fifo_pop, pop, empty, full;

    assign ret = tv[MEM_LAT-1];
`ifdef IMEM_BYPASS_EN
    assign byp = empty && ret && !flush && !stall;
`else
    assign byp = 1'b0;
`endif
    assign push = ret && !flush && !byp;
    assign fifo_pop = !empty && !stall;
    assign inst_valid = !empty || byp;
    assign pop = inst_valid && !stall;
    // Credits cover buffered plus in-flight entries, so a response always has a slot.
    assign cnt = count + inflight;
    assign pc_ready = reset && !flush && (cnt < (PW+1)'(DEPTH) || (cnt == (PW+1)'(DEPTH) && pop));
    assign re = pc_valid && pc_ready;
    assign addr = re ? pc : last_addr;
    assign {inst, inst_pc} = !empty ? head : byp ? {dout, tpc[MEM_LAT-1]} : '0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tv <= '0;
            last_addr <= '0;
            inflight <= '0;
            for (int i = 0; i < MEM_LAT; i++) tpc[i] <= '0;
        end else begin
            tv[0] <= re;
            tpc[0] <= pc;
            for (int i = 1; i < MEM_LAT; i++) begin
                tv[i] <= tv[i-1];
                tpc[i] <= tpc[i-1];
            end
            if (flush) tv <= '0;
            if (re) last_addr <= pc;
            inflight <= flush ? '0 : inflight + (PW+1)'(re) - (PW+1)'(ret);
        end
    end

    imem_fetch_fifo #(.DEPTH(DEPTH), .W(DW + AW)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .clr   (flush),
        .push  (push),
        .pop   (fifo_pop),
        .wdata ({dout, tpc[MEM_LAT-1]}),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    no_overflow: assert property (@(posedge clk) disable iff (!reset) !(push && full && !fifo_pop));
endmodule

// File: tb/tb_imem_fetch_buffer.sv
// tb_imem_fetch_buffer: randomized bench for imem_fetch_buffer against an issue-order scoreboard.
// Honours IMEM_BYPASS_EN the same way as the design.
module tb_imem_fetch_buffer;
    localparam int LAT = 3;
    localparam int DEPTH = 2;
`ifdef IMEM_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif
    typedef struct { int cyc; logic [31:0] pc; } ent_t;

    logic clk = 1'b0, reset = 1'b1, pc_valid = 1'b0, flush = 1'b0, stall = 1'b0;
    logic pc_ready, re, inst_valid;
    logic [31:0] pc = '0, dout = '0, addr, inst, inst_pc;
    ent_t outq[$], pend[$];
    int cyc = 0, passed = 0, total = 0;
    logic [31:0] last_addr = '0, e_pc, e_inst, e_addr, cur_p;
    bit e_valid, e_ready, e_re, e_pop, cur_fl;

    always #5 clk = ~clk;

    imem_fetch_buffer #(.AW(32), .DW(32), .MEM_LAT(LAT), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .pc(pc), .pc_valid(pc_valid), .pc_ready(pc_ready),
        .flush(flush), .stall(stall), .addr(addr), .re(re), .dout(dout),
        .inst(inst), .inst_pc(inst_pc), .inst_valid(inst_valid)
    );

    function automatic logic [31:0] memf(logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
    endfunction

    // Memory answers LAT cycles after issue; decode sees an entry once it is old enough.
    task automatic drive(bit v, logic [31:0] p, bit fl, bit st);
        int age;
        while (pend.size() > 0 && pend[0].cyc < cyc) void'(pend.pop_front());
        dout = (pend.size() > 0 && pend[0].cyc == cyc) ? memf(pend[0].pc) : $urandom;
        pc_valid = v; pc = p; flush = fl; stall = st; cur_p = p; cur_fl = fl;
        @(negedge clk);
        age = outq.size() > 0 ? cyc - outq[0].cyc : 0;
        e_valid = outq.size() > 0 && (age >= LAT + 1 || (BYP && age == LAT && !st && !fl));
        e_pc = e_valid ? outq[0].pc : 32'h0;
        e_inst = memf(e_pc);
        e_pop = e_valid && !st;
        e_ready = !fl && (outq.size() < DEPTH || (outq.size() == DEPTH && e_pop));
        e_re = v && e_ready;
        e_addr = e_re ? p : last_addr;
    endtask

    task automatic advance();
        @(posedge clk);
        if (e_pop) void'(outq.pop_front());
        if (e_re) begin
            outq.push_back(ent_t'{cyc, cur_p});
            pend.push_back(ent_t'{cyc + LAT, cur_p});
            last_addr = cur_p;
        end
        if (cur_fl) outq.delete();
        cyc++;
        #1;
    endtask

    task automatic test_reset();
        pc_valid = 1'b1; pc = 32'h100;
        #1 reset = 1'b0;
        #1;
        total++; if (inst_valid !== 1'b0) $display("FAIL reset inst_valid: got %b want 0", inst_valid); else passed++;
        total++; if (inst !== 32'h0) $display("FAIL reset inst: got %h want 0", inst); else passed++;
        total++; if (inst_pc !== 32'h0) $display("FAIL reset inst_pc: got %h want 0", inst_pc); else passed++;
        total++; if (re !== 1'b0) $display("FAIL reset re: got %b want 0", re); else passed++;
        total++; if (addr !== 32'h0) $display("FAIL reset addr: got %h want 0", addr); else passed++;
        @(negedge clk); reset = 1'b1; @(posedge clk); cyc++; #1;
        drive(1'b1, 32'h100, 1'b0, 1'b0);
        total++; if (re !== e_re || addr !== e_addr) $display("FAIL reset issue: got re=%b addr=%h want re=%b addr=%h", re, addr, e_re, e_addr); else passed++;
        advance();
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        advance();
        reset = 1'b0;
        #1;
        outq.delete(); last_addr = '0;
        total++; if (inst_valid !== 1'b0) $display("FAIL midfetch reset inst_valid: got %b want 0", inst_valid); else passed++;
        @(negedge clk); reset = 1'b1; @(posedge clk); cyc++; #1;
        repeat (LAT + 2) begin
            drive(1'b0, 32'h0, 1'b0, 1'b0);
            total++; if (inst_valid !== e_valid) $display("FAIL stale after reset inst_valid: got %b want %b", inst_valid, e_valid); else passed++;
            total++; if (pc_ready !== e_ready) $display("FAIL after reset pc_ready: got %b want %b", pc_ready, e_ready); else passed++;
            advance();
        end
    endtask

    task automatic test_stream();
        int i = 0;
        for (int n = 0; n < 20; n++) begin
            drive(i < 3, 32'(i * 4), 1'b0, 1'b0);
            total++; if (inst_valid !== e_valid) $display("FAIL stream inst_valid: got %b want %b", inst_valid, e_valid); else passed++;
            if (e_valid) begin
                total++; if (inst_pc !== e_pc) $display("FAIL stream inst_pc: got %h want %h", inst_pc, e_pc); else passed++;
                total++; if (inst !== e_inst) $display("FAIL stream inst: got %h want %h", inst, e_inst); else passed++;
            end
            total++; if (re !== e_re) $display("FAIL stream re: got %b want %b", re, e_re); else passed++;
            if (e_re) i++;
            advance();
        end
    endtask

    task automatic test_stall();
        int iss = 0;
        logic [31:0] nx = 32'h0;
        for (int n = 0; n < 16; n++) begin
            drive(1'b1, nx, 1'b0, n < 8);
            total++; if (pc_ready !== e_ready) $display("FAIL stall pc_ready: got %b want %b", pc_ready, e_ready); else passed++;
            total++; if (inst_valid !== e_valid) $display("FAIL stall inst_valid: got %b want %b", inst_valid, e_valid); else passed++;
            if (e_valid) begin
                total++; if (inst_pc !== e_pc) $display("FAIL stall inst_pc: got %h want %h", inst_pc, e_pc); else passed++;
            end
            if (n < 8 && re) iss++;
            if (e_re) nx += 32'd4;
            advance();
        end
        total++; if (iss != DEPTH) $display("FAIL stall issues: got %0d want %0d", iss, DEPTH); else passed++;
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        total++; if (pc_ready !== 1'b0 || re !== 1'b0) $display("FAIL stall flush: got ready=%b re=%b want 0 0", pc_ready, re); else passed++;
        advance();
    endtask

    task automatic test_flush();
        int seen = 0;
        bit done = 1'b0;
        drive(1'b1, 32'h10, 1'b0, 1'b0); advance();
        drive(1'b1, 32'h14, 1'b0, 1'b0); advance();
        drive(1'b1, 32'h18, 1'b1, 1'b0);
        total++; if (pc_ready !== 1'b0 || re !== 1'b0) $display("FAIL flush cycle: got ready=%b re=%b want 0 0", pc_ready, re); else passed++;
        advance();
        for (int n = 0; n < 10; n++) begin
            drive(!done, 32'h200, 1'b0, 1'b0);
            total++; if (inst_valid !== e_valid) $display("FAIL flush inst_valid: got %b want %b", inst_valid, e_valid); else passed++;
            if (e_valid) begin
                total++; if (inst_pc !== e_pc || inst !== e_inst) $display("FAIL flush redirect: got %h/%h want %h/%h", inst_pc, inst, e_pc, e_inst); else passed++;
            end
            if (inst_valid) seen++;
            if (e_re) done = 1'b1;
            advance();
        end
        total++; if (seen != 1) $display("FAIL flush delivered count: got %0d want 1", seen); else passed++;
    endtask

    task automatic test_full();
        int hit = 0;
        logic [31:0] nx = 32'h1000;
        for (int n = 0; n < 30; n++) begin
            drive(n < 24, nx, 1'b0, n < 6);
            total++; if (pc_ready !== e_ready) $display("FAIL full pc_ready: got %b want %b", pc_ready, e_ready); else passed++;
            total++; if (inst_valid !== e_valid) $display("FAIL full inst_valid: got %b want %b", inst_valid, e_valid); else passed++;
            if (e_valid) begin
                total++; if (inst_pc !== e_pc) $display("FAIL full order inst_pc: got %h want %h", inst_pc, e_pc); else passed++;
            end
            if (outq.size() == DEPTH && e_pop && pc_ready) hit++;
            if (e_re) nx += 32'd4;
            advance();
        end
        total++; if (hit == 0) $display("FAIL full pop-and-issue: got %0d cycles want >0", hit); else passed++;
    endtask

    task automatic test_flush_stall();
        for (int n = 0; n < LAT + 4; n++) begin
            drive(1'b1, 32'h300 + 32'(n * 4), 1'b0, 1'b1);
            advance();
        end
        drive(1'b0, 32'h0, 1'b1, 1'b1);
        total++; if (inst_valid !== e_valid) $display("FAIL flush+stall head: got %b want %b", inst_valid, e_valid); else passed++;
        advance();
        drive(1'b0, 32'h0, 1'b0, 1'b1);
        total++; if (inst_valid !== 1'b0) $display("FAIL flush+stall inst_valid: got %b want 0", inst_valid); else passed++;
        total++; if (pc_ready !== 1'b1) $display("FAIL flush+stall pc_ready: got %b want 1", pc_ready); else passed++;
        advance();
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            drive($urandom_range(3) != 0, {$urandom_range(255), 2'b00}, $urandom_range(24) == 0, $urandom_range(2) == 0);
            total++; if (inst_valid !== e_valid) $display("FAIL rand inst_valid: got %b want %b", inst_valid, e_valid); else passed++;
            if (e_valid) begin
                total++; if (inst_pc !== e_pc) $display("FAIL rand inst_pc: got %h want %h", inst_pc, e_pc); else passed++;
                total++; if (inst !== e_inst) $display("FAIL rand inst: got %h want %h", inst, e_inst); else passed++;
            end
            total++; if (pc_ready !== e_ready) $display("FAIL rand pc_ready: got %b want %b", pc_ready, e_ready); else passed++;
            total++; if (re !== e_re) $display("FAIL rand re: got %b want %b", re, e_re); else passed++;
            total++; if (addr !== e_addr) $display("FAIL rand addr: got %h want %h", addr, e_addr); else passed++;
            advance();
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_flush();
        test_full();
        test_flush_stall();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
